// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, grant encoding and
// requester class used for the instruction/data fairness toggle.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;

    typedef enum logic [1:0] {G_NONE, G_I, G_DR, G_DW} gnt_t;

    typedef enum logic {CLS_I, CLS_D} cls_t;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Counts cycles spent waiting on memory; saturates at LIMIT-1 so it never
// wraps back to zero, and flags when that last allowed cycle is reached.
module arb_timeout_ctr #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises icache refill, dcache refill and dcache write-through onto one
// single-ported memory, alternating between instruction and data classes.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ireq,
    input  logic [AW-1:0] iadr,
    output logic          ival,
    output logic [DW-1:0] irdata,
    input  logic          rreq,
    input  logic [AW-1:0] radr,
    output logic          rval,
    output logic [DW-1:0] rrdata,
    input  logic          wreq,
    input  logic [AW-1:0] wadr,
    input  logic [DW-1:0] wdata,
    output logic          wval,
    output logic          err,
    output logic          mreq,
    output logic          mwe,
    output logic [AW-1:0] madr,
    output logic [DW-1:0] mwdata,
    input  logic          mval,
    input  logic [DW-1:0] mrdata,
    output logic [1:0]    gnt,
    output logic          busy
);

    arb_state_t    state_reg;
    gnt_t          gnt_reg;
    cls_t          last_cls_reg;
    logic          mreq_reg;
    logic          mwe_reg;
    logic [AW-1:0] adr_reg;
    logic [DW-1:0] wdata_reg;
    logic          ival_reg;
    logic          rval_reg;
    logic          wval_reg;
    logic          err_reg;
    logic [DW-1:0] irdata_reg;
    logic [DW-1:0] rrdata_reg;

    gnt_t          win_gnt;
    cls_t          win_cls;
    logic          timer_expired;

    arb_timeout_ctr #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_reg == IDLE),
        .enable  (state_reg == BUSY),
        .expired (timer_expired)
    );

    // Class choice toggles only when both classes compete; inside the data
    // class a pending write always goes first so read-after-write stays ordered.
    always_comb begin
        win_gnt = G_NONE;
        win_cls = last_cls_reg;
        if (ireq && (wreq || rreq)) begin
            win_cls = (last_cls_reg == CLS_I) ? CLS_D : CLS_I;
        end else if (ireq) begin
            win_cls = CLS_I;
        end else begin
            win_cls = CLS_D;
        end
        if (ireq || wreq || rreq) begin
            if (win_cls == CLS_I) begin
                win_gnt = G_I;
            end else if (wreq) begin
                win_gnt = G_DW;
            end else begin
                win_gnt = G_DR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            gnt_reg      <= G_NONE;
            last_cls_reg <= CLS_I;
            mreq_reg     <= 1'b0;
            mwe_reg      <= 1'b0;
            adr_reg      <= '0;
            wdata_reg    <= '0;
            ival_reg     <= 1'b0;
            rval_reg     <= 1'b0;
            wval_reg     <= 1'b0;
            err_reg      <= 1'b0;
            irdata_reg   <= '0;
            rrdata_reg   <= '0;
        end else begin
            ival_reg <= 1'b0;
            rval_reg <= 1'b0;
            wval_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    err_reg <= 1'b0;
                    if (win_gnt != G_NONE) begin
                        gnt_reg      <= win_gnt;
                        last_cls_reg <= win_cls;
                        mreq_reg     <= 1'b1;
                        state_reg    <= BUSY;
                        case (win_gnt)
                            G_I: begin
                                adr_reg <= iadr;
                                mwe_reg <= 1'b0;
                            end
                            G_DW: begin
                                adr_reg   <= wadr;
                                wdata_reg <= wdata;
                                mwe_reg   <= 1'b1;
                            end
                            default: begin
                                adr_reg <= radr;
                                mwe_reg <= 1'b0;
                            end
                        endcase
                    end
                end
                BUSY: begin
                    // An ack on the expiry cycle still wins: success, no error.
                    if (mval || timer_expired) begin
                        state_reg <= RESP;
                        mreq_reg  <= 1'b0;
                        mwe_reg   <= 1'b0;
                        err_reg   <= !mval;
                        case (gnt_reg)
                            G_I: begin
                                ival_reg <= 1'b1;
                                if (mval) irdata_reg <= mrdata;
                            end
                            G_DR: begin
                                rval_reg <= 1'b1;
                                if (mval) rrdata_reg <= mrdata;
                            end
                            G_DW:    wval_reg <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                RESP: begin
                    err_reg   <= 1'b0;
                    gnt_reg   <= G_NONE;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ival   = ival_reg;
    assign rval   = rval_reg;
    assign wval   = wval_reg;
    assign err    = err_reg;
    assign irdata = irdata_reg;
    assign rrdata = rrdata_reg;
    assign mreq   = mreq_reg;
    assign mwe    = mwe_reg;
    assign madr   = adr_reg;
    assign mwdata = wdata_reg;
    assign gnt    = gnt_reg;
    assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: each scenario task drives the requesters
// and a hand-driven memory ack, comparing outputs 1ns after each rising edge.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          ireq, rreq, wreq;
    logic [AW-1:0] iadr, radr, wadr;
    logic [DW-1:0] wdata;
    logic          ival, rval, wval, err;
    logic [DW-1:0] irdata, rrdata;
    logic          mreq, mwe;
    logic [AW-1:0] madr;
    logic [DW-1:0] mwdata;
    logic          mval;
    logic [DW-1:0] mrdata;
    logic [1:0]    gnt;
    logic          busy;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .ireq(ireq), .iadr(iadr), .ival(ival), .irdata(irdata),
        .rreq(rreq), .radr(radr), .rval(rval), .rrdata(rrdata),
        .wreq(wreq), .wadr(wadr), .wdata(wdata), .wval(wval),
        .err(err), .mreq(mreq), .mwe(mwe), .madr(madr), .mwdata(mwdata),
        .mval(mval), .mrdata(mrdata), .gnt(gnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        total++; if (mreq !== 1'b0) begin bad++; $display("FAIL reset_mreq got=%b want=0", mreq); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (gnt !== 2'd0) begin bad++; $display("FAIL reset_gnt got=%0d want=0", gnt); end
        total++; if (madr !== 32'h0) begin bad++; $display("FAIL reset_madr got=%h want=0", madr); end
        total++; if ({ival, rval, wval, err, mwe} !== 5'b0) begin bad++; $display("FAIL reset_vals got=%b want=00000", {ival, rval, wval, err, mwe}); end
        reset = 1'b1;
        step();
        $display("txn reset: mreq=%b busy=%b gnt=%0d", mreq, busy, gnt);
    endtask

    task automatic test_icache_read();
        ireq = 1'b1; iadr = 32'h40;
        step();
        total++; if (mreq !== 1'b1 || madr !== 32'h40 || mwe !== 1'b0) begin bad++; $display("FAIL ird_busy1 got mreq=%b madr=%h mwe=%b want 1/40/0", mreq, madr, mwe); end
        total++; if (gnt !== 2'd1) begin bad++; $display("FAIL ird_gnt1 got=%0d want=1", gnt); end
        step();
        total++; if (gnt !== 2'd1 || ival !== 1'b0) begin bad++; $display("FAIL ird_busy2 got gnt=%0d ival=%b want 1/0", gnt, ival); end
        mval = 1'b1; mrdata = 32'h8C020000;
        step();
        total++; if (ival !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL ird_resp got ival=%b err=%b want 1/0", ival, err); end
        total++; if (irdata !== 32'h8C020000) begin bad++; $display("FAIL ird_data got=%h want=8c020000", irdata); end
        total++; if (gnt !== 2'd1 || mreq !== 1'b0) begin bad++; $display("FAIL ird_resp_gnt got gnt=%0d mreq=%b want 1/0", gnt, mreq); end
        ireq = 1'b0; mval = 1'b0;
        step();
        total++; if (ival !== 1'b0 || busy !== 1'b0 || gnt !== 2'd0) begin bad++; $display("FAIL ird_idle got ival=%b busy=%b gnt=%0d want 0/0/0", ival, busy, gnt); end
        $display("txn icache read adr=40 data=%h", irdata);
    endtask

    task automatic test_write_before_read();
        wreq = 1'b1; wadr = 32'h80; wdata = 32'h1234;
        rreq = 1'b1; radr = 32'h90;
        step();
        total++; if (gnt !== 2'd3 || mwe !== 1'b1) begin bad++; $display("FAIL wr_first got gnt=%0d mwe=%b want 3/1", gnt, mwe); end
        total++; if (madr !== 32'h80 || mwdata !== 32'h1234) begin bad++; $display("FAIL wr_bus got madr=%h mwdata=%h want 80/1234", madr, mwdata); end
        mval = 1'b1;
        step();
        total++; if (wval !== 1'b1 || rval !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL wr_resp got wval=%b rval=%b err=%b want 1/0/0", wval, rval, err); end
        wreq = 1'b0; mval = 1'b0;
        $display("txn dcache write adr=80 data=1234");
        step();
        step();
        total++; if (gnt !== 2'd2 || mwe !== 1'b0 || madr !== 32'h90) begin bad++; $display("FAIL rd_second got gnt=%0d mwe=%b madr=%h want 2/0/90", gnt, mwe, madr); end
        mval = 1'b1; mrdata = 32'hAAAA5555;
        step();
        total++; if (rval !== 1'b1 || wval !== 1'b0 || rrdata !== 32'hAAAA5555) begin bad++; $display("FAIL rd_resp got rval=%b wval=%b rrdata=%h want 1/0/aaaa5555", rval, wval, rrdata); end
        rreq = 1'b0; mval = 1'b0;
        step();
        $display("txn dcache read adr=90 data=%h", rrdata);
    endtask

    task automatic test_fairness();
        logic [1:0] exp_g [4];
        exp_g = '{2'd2, 2'd1, 2'd2, 2'd1};
        reset = 1'b0;
        step();
        reset = 1'b1;
        ireq = 1'b1; iadr = 32'h100;
        rreq = 1'b1; radr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if (gnt !== exp_g[k]) begin bad++; $display("FAIL fair_gnt%0d got=%0d want=%0d", k, gnt, exp_g[k]); end
            mval = 1'b1; mrdata = 32'hD000 + 32'(k);
            step();
            if (exp_g[k] == 2'd1) begin
                total++; if (ival !== 1'b1 || irdata !== 32'hD000 + 32'(k)) begin bad++; $display("FAIL fair_ival%0d got ival=%b data=%h want 1/%h", k, ival, irdata, 32'hD000 + 32'(k)); end
            end else begin
                total++; if (rval !== 1'b1 || rrdata !== 32'hD000 + 32'(k)) begin bad++; $display("FAIL fair_rval%0d got rval=%b data=%h want 1/%h", k, rval, rrdata, 32'hD000 + 32'(k)); end
            end
            mval = 1'b0;
            step();
            $display("txn fairness k=%0d gnt=%0d", k, exp_g[k]);
        end
        ireq = 1'b0; rreq = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        rreq = 1'b1; radr = 32'h300;
        step();
        n = mreq ? 1 : 0;
        for (int c = 0; c < TO + 4; c++) begin
            step();
            if (mreq) n++;
            else break;
        end
        total++; if (n !== TO) begin bad++; $display("FAIL to_mreq_cycles got=%0d want=%0d", n, TO); end
        total++; if (rval !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL to_resp got rval=%b err=%b want 1/1", rval, err); end
        total++; if (rrdata !== 32'hD002) begin bad++; $display("FAIL to_rrdata_hold got=%h want=0000d002", rrdata); end
        rreq = 1'b0;
        step();
        total++; if (busy !== 1'b0 || err !== 1'b0 || rval !== 1'b0) begin bad++; $display("FAIL to_idle got busy=%b err=%b rval=%b want 0/0/0", busy, err, rval); end
        $display("txn dcache read timeout after %0d cycles", n);
    endtask

    task automatic test_ack_at_limit();
        rreq = 1'b1; radr = 32'h304;
        step();
        for (int c = 0; c < TO - 1; c++) step();
        total++; if (mreq !== 1'b1) begin bad++; $display("FAIL lim_still_busy got mreq=%b want 1", mreq); end
        mval = 1'b1; mrdata = 32'h0BADF00D;
        step();
        total++; if (rval !== 1'b1 || err !== 1'b0 || rrdata !== 32'h0BADF00D) begin bad++; $display("FAIL lim_ack got rval=%b err=%b data=%h want 1/0/0badf00d", rval, err, rrdata); end
        rreq = 1'b0; mval = 1'b0;
        step();
        $display("txn dcache read acked on last cycle data=%h", rrdata);
    endtask

    task automatic test_reset_mid_busy();
        ireq = 1'b1; iadr = 32'h500;
        step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy got=%b want=1", busy); end
        reset = 1'b0;
        step();
        total++; if (mreq !== 1'b0 || busy !== 1'b0 || gnt !== 2'd0 || ival !== 1'b0) begin bad++; $display("FAIL rst_mid_drop got mreq=%b busy=%b gnt=%0d ival=%b want 0/0/0/0", mreq, busy, gnt, ival); end
        reset = 1'b1;
        step();
        total++; if (gnt !== 2'd1 || madr !== 32'h500 || mreq !== 1'b1) begin bad++; $display("FAIL rst_regrant got gnt=%0d madr=%h mreq=%b want 1/500/1", gnt, madr, mreq); end
        mval = 1'b1; mrdata = 32'h55;
        step();
        ireq = 1'b0; mval = 1'b0;
        step();
        $display("txn reset during busy, then icache read adr=500");
    endtask

    task automatic test_spurious_and_stable();
        mval = 1'b1; mrdata = 32'hDEAD;
        step();
        total++; if (busy !== 1'b0 || {ival, rval, wval} !== 3'b0 || irdata !== 32'h55) begin bad++; $display("FAIL spur_ignored got busy=%b vals=%b irdata=%h want 0/000/55", busy, {ival, rval, wval}, irdata); end
        mval = 1'b0;
        ireq = 1'b1; iadr = 32'h44;
        step();
        iadr = 32'h88;
        step();
        total++; if (madr !== 32'h44 || mreq !== 1'b1) begin bad++; $display("FAIL stable_madr got madr=%h mreq=%b want 44/1", madr, mreq); end
        mval = 1'b1; mrdata = 32'h5;
        step();
        total++; if (ival !== 1'b1 || irdata !== 32'h5 || madr !== 32'h44) begin bad++; $display("FAIL stable_resp got ival=%b irdata=%h madr=%h want 1/5/44", ival, irdata, madr); end
        ireq = 1'b0; mval = 1'b0;
        step();
        $display("txn icache read adr=44 with iadr changed mid-busy");
    endtask

    initial begin
        reset = 1'b0;
        ireq = 1'b0; rreq = 1'b0; wreq = 1'b0;
        iadr = '0; radr = '0; wadr = '0; wdata = '0;
        mval = 1'b0; mrdata = '0;
        test_reset();
        test_icache_read();
        test_write_before_read();
        test_fairness();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid_busy();
        test_spurious_and_stable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
